// File: rtl/shake_squeeze_streamer.sv
// SHAKE squeeze-output stage: serialises Keccak rate blocks into W-bit words with last/zero-masking.
// Optional byte-lane keep output (data_out_keep) is compiled in when SHAKE_STREAM_KEEP_EN is defined.
module shake_squeeze_streamer #(
  parameter int         W                 = 64,
  parameter int         RATE_MAX          = 1344,
  parameter int         SIZE_W            = 32,
  parameter logic [1:0] SHAKE256_MODE_VEC = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SIZE_W-1:0]   output_size,
  input  logic [1:0]          operation_mode,
  input  logic [RATE_MAX-1:0] rate_output,
  input  logic                block_valid,
  output logic                block_ready,
  output logic                squeeze_req,
  output logic [W-1:0]        data_out,
  output logic                data_out_valid,
  input  logic                data_out_ready,
  output logic                data_out_last,
`ifdef SHAKE_STREAM_KEEP_EN
  output logic [W/8-1:0]      data_out_keep,
`endif
  output logic                done
);

  localparam int BPW    = W / 8;
  localparam int BPW_LG = $clog2(BPW);
  localparam int CNT_W  = SIZE_W - 3;
  localparam int WCNT_W = $clog2(1344 / W + 1);
  localparam logic [WCNT_W-1:0] RW128 = WCNT_W'(1344 / W);
  localparam logic [WCNT_W-1:0] RW256 = WCNT_W'(1088 / W);

  typedef enum logic [1:0] {IDLE, WAIT_BLK, DRAIN, FIN} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    bytes_left;
  logic [WCNT_W-1:0]   rate_words;
  logic [WCNT_W-1:0]   words_blk;
  logic [RATE_MAX-1:0] buffer;
  logic                sq_nxt;

  logic                drain, hs, is_last;
  logic [CNT_W-1:0]    take, bytes_nxt;
  logic [CNT_W:0]      blk_need;
  logic [WCNT_W-1:0]   words_load;
  logic [BPW-1:0]      keep;
  logic                unused_size_bits;

  // Lanes holding valid bytes: the r upper lanes of the final word, all lanes otherwise.
  function automatic logic [BPW-1:0] lane_keep(input logic [CNT_W-1:0] bl);
    logic [CNT_W-1:0] r;
    logic [BPW-1:0]   k;
    r = bl % CNT_W'(BPW);
    k = '1;
    if (bl <= CNT_W'(BPW) && r != '0) begin
      for (int i = 0; i < BPW; i++) k[i] = (CNT_W'(i) >= (CNT_W'(BPW) - r));
    end
    return k;
  endfunction

  function automatic logic [W-1:0] apply_mask(input logic [W-1:0] w, input logic [BPW-1:0] k);
    logic [W-1:0] m;
    for (int i = 0; i < BPW; i++) m[8*i +: 8] = k[i] ? w[8*i +: 8] : 8'h00;
    return m;
  endfunction

  assign unused_size_bits = ^output_size[2:0];

  assign drain     = (state == DRAIN);
  assign hs        = drain && data_out_ready;
  assign is_last   = (bytes_left <= CNT_W'(BPW));
  assign take      = is_last ? bytes_left : CNT_W'(BPW);
  assign bytes_nxt = bytes_left - take;
  assign blk_need  = ({1'b0, bytes_left} + (CNT_W+1)'(BPW - 1)) >> BPW_LG;
  assign words_load = (blk_need > (CNT_W+1)'(rate_words)) ? rate_words : WCNT_W'(blk_need);
  assign keep      = lane_keep(bytes_left);

  assign block_ready    = (state == WAIT_BLK);
  assign data_out_valid = drain;
  assign data_out_last  = drain && is_last;
  assign data_out       = drain ? apply_mask(buffer[W-1:0], keep) : '0;
  assign done           = (state == FIN);
`ifdef SHAKE_STREAM_KEEP_EN
  assign data_out_keep  = drain ? keep : '0;
`endif

  always_comb begin
    state_nxt = state;
    sq_nxt    = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = (output_size[SIZE_W-1:3] != '0) ? WAIT_BLK : FIN;
      WAIT_BLK: if (block_valid) state_nxt = DRAIN;
      DRAIN: begin
        if (hs && words_blk == WCNT_W'(1)) begin
          if (bytes_nxt == '0) begin
            state_nxt = FIN;
          end else begin
            state_nxt = WAIT_BLK;
            sq_nxt    = 1'b1;
          end
        end
      end
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      squeeze_req <= 1'b0;
    end else begin
      state       <= state_nxt;
      squeeze_req <= sq_nxt;
    end
  end

  // Request length, block load and PISO shift
  always_ff @(posedge clk) begin
    if (!rst) begin
      bytes_left <= '0;
      rate_words <= '0;
      words_blk  <= '0;
      buffer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bytes_left <= output_size[SIZE_W-1:3];
            rate_words <= (operation_mode == SHAKE256_MODE_VEC) ? RW256 : RW128;
          end
        end
        WAIT_BLK: begin
          if (block_valid) begin
            buffer    <= rate_output;
            words_blk <= words_load;
          end
        end
        DRAIN: begin
          if (hs) begin
            buffer     <= buffer >> W;
            bytes_left <= bytes_nxt;
            words_blk  <= words_blk - WCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shake_squeeze_streamer.sv
// Directed self-checking bench for shake_squeeze_streamer (W=64); keep checks follow SHAKE_STREAM_KEEP_EN.
module tb_shake_squeeze_streamer;

  localparam logic [1:0] M128 = 2'b00;
  localparam logic [1:0] M256 = 2'b01;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   output_size;
  logic [1:0]    operation_mode;
  logic [1343:0] rate_output;
  logic          block_valid;
  logic          block_ready;
  logic          squeeze_req;
  logic [63:0]   data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic          data_out_last;
  logic          done;
`ifdef SHAKE_STREAM_KEEP_EN
  logic [7:0]    data_out_keep;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shake_squeeze_streamer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .output_size    (output_size),
    .operation_mode (operation_mode),
    .rate_output    (rate_output),
    .block_valid    (block_valid),
    .block_ready    (block_ready),
    .squeeze_req    (squeeze_req),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_last  (data_out_last),
`ifdef SHAKE_STREAM_KEEP_EN
    .data_out_keep  (data_out_keep),
`endif
    .done           (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] blk_word(input int b, input int i);
    return {8'hA5, 8'(b), 16'h1234, 16'(i * 3 + 1), 16'(i)};
  endfunction

  function automatic logic [1343:0] make_blk(input int b);
    logic [1343:0] blk;
    for (int i = 0; i < 21; i++) blk[64*i +: 64] = blk_word(b, i);
    return blk;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request; the bench model tracks remaining bytes, block and word index.
  task automatic run_req(input int size, input logic [1:0] mode, input bit toggle,
                         input int abort_at, input int spurious_at,
                         output int words, output int sq, output int done_cyc,
                         output int br_cnt, output logic [63:0] last_w);
    int rem, rw, b, i, cyc, nb, r;
    bit sq_due, blk_prev, aborted, got_done;
    logic [63:0] exp_w;
    logic        exp_last;
    logic [7:0]  exp_keep;
    rem = size / 8; rw = (mode == M256) ? 17 : 21;
    b = 0; i = 0; nb = 0; words = 0; sq = 0; done_cyc = -1; br_cnt = 0; last_w = '0;
    sq_due = 0; blk_prev = 0; aborted = 0; got_done = 0;
    start = 1'b1; output_size = size; operation_mode = mode;
    step();
    cyc = 1;
    while (cyc < 400 && !got_done) begin
      start = 1'b0;
      block_valid = 1'b0;
      if (blk_prev) chk("first_valid_latency", 64'(data_out_valid), 64'd1);
      blk_prev = 0;
      if (sq_due) begin
        chk("squeeze_pulse", 64'(squeeze_req), 64'd1);
        chk("ready_with_squeeze", 64'(block_ready), 64'd1);
      end
      sq_due = 0;
      if (squeeze_req) sq++;
      if (block_ready) br_cnt++;
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
      end else begin
        if (data_out_valid) begin
          exp_last = (rem <= 8);
          r = rem % 8;
          exp_keep = (exp_last && r != 0) ? (8'hFF << (8 - r)) : 8'hFF;
          exp_w = blk_word(b, i);
          for (int l = 0; l < 8; l++) if (!exp_keep[l]) exp_w[8*l +: 8] = 8'h00;
          chk("data_word", data_out, exp_w);
          chk("last_flag", 64'(data_out_last), 64'(exp_last));
`ifdef SHAKE_STREAM_KEEP_EN
          chk("keep_lanes", 64'(data_out_keep), 64'(exp_keep));
`endif
          if (abort_at >= 0 && words == abort_at) begin
            rst = 1'b0;
            aborted = 1;
            break;
          end
          data_out_ready = toggle ? cyc[0] : 1'b1;
          if (data_out_ready) begin
            words++;
            last_w = data_out;
            rem = rem - ((rem < 8) ? rem : 8);
            i++;
            if (i == rw && rem > 0) begin
              b++; i = 0; sq_due = 1;
            end
          end
        end else begin
          data_out_ready = toggle ? cyc[0] : 1'b1;
        end
        if (spurious_at >= 0 && words == spurious_at && data_out_valid) begin
          start = 1'b1; output_size = 32'd7992;
        end
        if (block_ready) begin
          block_valid = 1'b1;
          rate_output = make_blk(nb);
          nb++;
          blk_prev = 1;
        end
        step();
        cyc++;
      end
    end
    start = 1'b0;
    block_valid = 1'b0;
    if (aborted) begin
      step();
      chk("rst_block_ready", 64'(block_ready), 64'd0);
      chk("rst_squeeze_req", 64'(squeeze_req), 64'd0);
      chk("rst_valid", 64'(data_out_valid), 64'd0);
      chk("rst_data", data_out, 64'd0);
      chk("rst_last", 64'(data_out_last), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      rst = 1'b1;
      step();
    end else begin
      chk("done_seen", 64'(got_done), 64'd1);
      step();
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("idle_after_done", 64'(block_ready), 64'd0);
    end
  endtask

  initial begin
    int words, sq, dc, brc;
    logic [63:0] lw;
    rst = 1'b0; start = 1'b0; output_size = '0; operation_mode = '0;
    rate_output = '0; block_valid = 1'b0; data_out_ready = 1'b0;
    repeat (3) step();
    chk("reset_valid", 64'(data_out_valid), 64'd0);
    chk("reset_block_ready", 64'(block_ready), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_data", data_out, 64'd0);
`ifdef SHAKE_STREAM_KEEP_EN
    chk("reset_keep", 64'(data_out_keep), 64'd0);
`endif
    rst = 1'b1;
    step();

    // SHAKE128, 256 bits: 4 back-to-back words, done on the 6th cycle after start
    run_req(256, M128, 0, -1, -1, words, sq, dc, brc, lw);
    chk("t1_words", 64'(words), 64'd4);
    chk("t1_squeeze", 64'(sq), 64'd0);
    chk("t1_done_cycle", 64'(dc), 64'd6);
    chk("t1_last_word", lw, 64'hA500_1234_000A_0003);

    // SHAKE256, 1120 bits: 17 + 1 words, final word upper half only
    run_req(1120, M256, 0, -1, -1, words, sq, dc, brc, lw);
    chk("t2_words", 64'(words), 64'd18);
    chk("t2_squeeze", 64'(sq), 64'd1);
    chk("t2_last_word", lw, 64'hA501_1234_0000_0000);

    // Non-SHAKE256 mode code, 2688 bits, ready toggling: 42 words over two blocks
    run_req(2688, 2'b10, 1, -1, -1, words, sq, dc, brc, lw);
    chk("t3_words", 64'(words), 64'd42);
    chk("t3_squeeze", 64'(sq), 64'd1);
    chk("t3_last_word", lw, 64'hA501_1234_003D_0014);

    // Zero-length request: no block, no data, prompt done
    run_req(0, M128, 0, -1, -1, words, sq, dc, brc, lw);
    chk("t4_words", 64'(words), 64'd0);
    chk("t4_block_ready", 64'(brc), 64'd0);
    chk("t4_done_latency", 64'(dc >= 1 && dc <= 2), 64'd1);

    // Reset while presenting word 5, then a fresh single-word request
    run_req(2688, M128, 0, 4, -1, words, sq, dc, brc, lw);
    chk("t5_words_before_rst", 64'(words), 64'd4);
    run_req(64, M128, 0, -1, -1, words, sq, dc, brc, lw);
    chk("t5_words", 64'(words), 64'd1);
    chk("t5_done_cycle", 64'(dc), 64'd3);
    chk("t5_last_word", lw, 64'hA500_1234_0001_0000);

    // start during DRAIN is ignored
    run_req(256, M128, 0, -1, 1, words, sq, dc, brc, lw);
    chk("t6_words", 64'(words), 64'd4);
    chk("t6_done_cycle", 64'(dc), 64'd6);
    chk("t6_last_word", lw, 64'hA500_1234_000A_0003);

    // 15 bits -> 1 byte: only the top lane survives
    run_req(15, M256, 0, -1, -1, words, sq, dc, brc, lw);
    chk("t7_words", 64'(words), 64'd1);
    chk("t7_last_word", lw, 64'hA500_0000_0000_0000);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
